// File: rtl/mic_clk_gen.sv
// -----------------------------------------------------------------------------
// mic_clk_gen
// Runtime-programmable microphone-array clock generator. From the system
// clock it derives the mic bit clock (sck) and word select (ws), plus
// system-domain edge strobes, bit index, frame markers, a frame counter and a
// ready flag for downstream beamforming logic. Divider settings are captured
// into a shadow register and only take effect on frame boundaries while
// running (immediately when idle).
//
// Optional feature macro: MIC_CLKGEN_WARMUP_EN
//   defined   : ready is held low for WARMUP_FRAMES frames after start from IDLE
//   undefined : ready is high from the cycle after RUN entry until IDLE
//
// Ports
//   clk_in          system clock
//   rst             synchronous, active-high reset
//   en              run request
//   cfg_half_div    requested sck half-period in clk_in cycles
//   cfg_frame_bits  requested sck cycles per ws frame
//   cfg_load        one-cycle capture strobe for both cfg_* fields
//   cfg_ack         one-cycle pulse when captured values become active
//   sck, ws         registered mic bit clock and word select
//   sck_rise/fall   one-cycle strobes coincident with the registered sck edge
//   bit_idx         current bit within the frame
//   frame_start     one-cycle pulse when bit_idx wraps to 0
//   ready           mic data valid
//   frame_cnt       frames completed while ready (wraps)
// -----------------------------------------------------------------------------
module mic_clk_gen #(
  parameter int DIV_W          = 8,
  parameter int BITS_W         = 8,
  parameter int DEF_HALF_DIV   = 15,
  parameter int DEF_FRAME_BITS = 64,
  parameter int WARMUP_FRAMES  = 16,
  parameter int FCNT_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  cfg_half_div,
  input  logic [BITS_W-1:0] cfg_frame_bits,
  input  logic              cfg_load,
  output logic              cfg_ack,
  output logic              sck,
  output logic              ws,
  output logic              sck_rise,
  output logic              sck_fall,
  output logic [BITS_W-1:0] bit_idx,
  output logic              frame_start,
  output logic              ready,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Reset configuration, sanitised the same way as runtime captures.
  localparam int DEF_BITS_EVEN = DEF_FRAME_BITS - (DEF_FRAME_BITS % 2);
  localparam logic [DIV_W-1:0] RST_DIV =
    (DEF_HALF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_HALF_DIV);
  localparam logic [BITS_W-1:0] RST_BITS =
    (DEF_BITS_EVEN < 2) ? BITS_W'(2) : BITS_W'(DEF_BITS_EVEN);

  state_t r_state;
  state_t w_state_next;

  logic [DIV_W-1:0]  r_half_div;
  logic [BITS_W-1:0] r_frame_bits;
  logic [DIV_W-1:0]  r_sh_half_div;
  logic [BITS_W-1:0] r_sh_frame_bits;
  logic              r_sh_pending;

  logic [DIV_W-1:0]  r_hc;
  logic              r_sck;
  logic              r_ws;
  logic              r_sck_rise;
  logic              r_sck_fall;
  logic [BITS_W-1:0] r_bit_idx;
  logic              r_frame_start;
  logic              r_cfg_ack;
  logic              r_ready;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic              w_active;
  logic              w_tc;
  logic              w_rise;
  logic              w_fall;
  logic              w_last_bit;
  logic              w_wrap;
  logic [BITS_W-1:0] w_bit_inc;
  logic              w_ready_next;
  logic              w_warm_done;
  logic [DIV_W-1:0]  w_san_div;
  logic [BITS_W-1:0] w_san_bits;
  logic [BITS_W-1:0] w_bits_even;

  // Capture-time sanitisation: half_div >= 1, frame_bits even and >= 2.
  assign w_san_div   = (cfg_half_div == '0) ? DIV_W'(1) : cfg_half_div;
  assign w_bits_even = {cfg_frame_bits[BITS_W-1:1], 1'b0};
  assign w_san_bits  = (w_bits_even < BITS_W'(2)) ? BITS_W'(2) : w_bits_even;

  assign w_active   = (r_state != ST_IDLE);
  assign w_tc       = w_active && (r_hc == (r_half_div - DIV_W'(1)));
  assign w_rise     = w_tc && !r_sck;
  assign w_fall     = w_tc && r_sck;
  assign w_last_bit = (r_bit_idx == (r_frame_bits - BITS_W'(1)));
  // Frame boundary: the sck falling edge that closes the last bit.
  assign w_wrap     = w_fall && w_last_bit;
  assign w_bit_inc  = r_bit_idx + BITS_W'(1);

`ifdef MIC_CLKGEN_WARMUP_EN
  localparam int WARM_W = $clog2(WARMUP_FRAMES + 2);
  logic [WARM_W-1:0] r_warm_cnt;

  assign w_warm_done = (r_warm_cnt >= WARM_W'(WARMUP_FRAMES));

  // Counts frame_start pulses since the last start from IDLE; a return
  // from DRAIN keeps the count so warm-up is not repeated.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_warm_cnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_next == ST_RUN)) begin
      r_warm_cnt <= '0;
    end else if (w_wrap && !w_warm_done) begin
      r_warm_cnt <= r_warm_cnt + WARM_W'(1);
    end
  end
`else
  // No warm-up in this build; the WARMUP_FRAMES term is constant false.
  assign w_warm_done = 1'b1 | (WARMUP_FRAMES < 0);
`endif

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_next = ST_RUN;
      ST_RUN:   if (!en) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        // A returning run request wins over stopping at the boundary.
        if (en) begin
          w_state_next = ST_RUN;
        end else if (w_wrap) begin
          w_state_next = ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
    // Not ready in the RUN entry cycle, nor once heading back to IDLE.
    w_ready_next = (r_state != ST_IDLE) && (w_state_next != ST_IDLE) && w_warm_done;
  end

  // ---------------------------------------------------------------------------
  // Clock / bit / frame datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_hc          <= '0;
      r_sck         <= 1'b0;
      r_ws          <= 1'b0;
      r_sck_rise    <= 1'b0;
      r_sck_fall    <= 1'b0;
      r_bit_idx     <= '0;
      r_frame_start <= 1'b0;
      r_ready       <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_sck_rise    <= 1'b0;
      r_sck_fall    <= 1'b0;
      r_frame_start <= 1'b0;
      r_ready       <= w_ready_next;

      if (r_state == ST_IDLE) begin
        r_hc      <= '0;
        r_sck     <= 1'b0;
        r_ws      <= 1'b0;
        r_bit_idx <= '0;
      end else if (w_tc) begin
        r_hc       <= '0;
        r_sck      <= ~r_sck;
        r_sck_rise <= w_rise;
        r_sck_fall <= w_fall;
        if (w_fall) begin
          if (w_last_bit) begin
            // The boundary edge is also a falling edge, so the DRAIN->IDLE
            // exit lands here with sck, ws and bit_idx already at 0.
            r_bit_idx     <= '0;
            r_ws          <= 1'b0;
            r_frame_start <= 1'b1;
          end else begin
            r_bit_idx <= w_bit_inc;
            r_ws      <= (w_bit_inc >= (r_frame_bits >> 1));
          end
        end
      end else begin
        r_hc <= r_hc + DIV_W'(1);
      end

      if (w_wrap && r_ready) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration: shadow capture and boundary apply
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_half_div      <= RST_DIV;
      r_frame_bits    <= RST_BITS;
      r_sh_half_div   <= RST_DIV;
      r_sh_frame_bits <= RST_BITS;
      r_sh_pending    <= 1'b0;
      r_cfg_ack       <= 1'b0;
    end else begin
      r_cfg_ack <= 1'b0;

      // Apply a pending shadow at the boundary; the new half_div then drives
      // the very next hc count because hc restarts from 0 in this cycle.
      if (w_wrap && r_sh_pending) begin
        r_half_div   <= r_sh_half_div;
        r_frame_bits <= r_sh_frame_bits;
        r_sh_pending <= 1'b0;
        r_cfg_ack    <= 1'b1;
      end

      // A load on the boundary edge itself waits for the following boundary.
      if (cfg_load) begin
        r_sh_half_div   <= w_san_div;
        r_sh_frame_bits <= w_san_bits;
        if (r_state == ST_IDLE) begin
          r_half_div   <= w_san_div;
          r_frame_bits <= w_san_bits;
          r_sh_pending <= 1'b0;
          r_cfg_ack    <= 1'b1;
        end else begin
          r_sh_pending <= 1'b1;
        end
      end
    end
  end

  assign cfg_ack     = r_cfg_ack;
  assign sck         = r_sck;
  assign ws          = r_ws;
  assign sck_rise    = r_sck_rise;
  assign sck_fall    = r_sck_fall;
  assign bit_idx     = r_bit_idx;
  assign frame_start = r_frame_start;
  assign ready       = r_ready;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_mic_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_mic_clk_gen
// Self-checking bench for mic_clk_gen with default parameters. A table of
// {cfg inputs, expected timing} records is applied from IDLE, plus directed
// sequences for defaults, mid-frame reconfiguration, drain, reset with a
// pending shadow, and ready/warm-up timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mic_clk_gen;

  localparam int DIV_W  = 8;
  localparam int BITS_W = 8;
  localparam int FCNT_W = 16;

  localparam int W_RISE = 0;
  localparam int W_FALL = 1;
  localparam int W_FS   = 2;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  cfg_half_div;
  logic [BITS_W-1:0] cfg_frame_bits;
  logic              cfg_load;
  logic              cfg_ack;
  logic              sck;
  logic              ws;
  logic              sck_rise;
  logic              sck_fall;
  logic [BITS_W-1:0] bit_idx;
  logic              frame_start;
  logic              ready;
  logic [FCNT_W-1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;

  mic_clk_gen dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .en             (en),
    .cfg_half_div   (cfg_half_div),
    .cfg_frame_bits (cfg_frame_bits),
    .cfg_load       (cfg_load),
    .cfg_ack        (cfg_ack),
    .sck            (sck),
    .ws             (ws),
    .sck_rise       (sck_rise),
    .sck_fall       (sck_fall),
    .bit_idx        (bit_idx),
    .frame_start    (frame_start),
    .ready          (ready),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) if (cfg_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  typedef struct {
    logic [DIV_W-1:0]  hd_in;
    logic [BITS_W-1:0] fb_in;
    int                exp_rise;
    int                exp_period;
    int                exp_frame;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Step until the selected strobe is seen in the current cycle.
  task automatic wait_for(input int which, input int limit, input string name);
    logic hit;
    int   n;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < limit) begin
      step();
      n++;
      case (which)
        W_RISE:  hit = (sck_rise === 1'b1);
        W_FALL:  hit = (sck_fall === 1'b1);
        default: hit = (frame_start === 1'b1);
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: no strobe within %0d cycles, required one", name, limit);
    end
  endtask

  task automatic load(input logic [DIV_W-1:0] hd, input logic [BITS_W-1:0] fb);
    cfg_half_div   = hd;
    cfg_frame_bits = fb;
    cfg_load       = 1'b1;
    step();
    cfg_load       = 1'b0;
  endtask

  initial begin
    int c0, c1, f0, f1, ack0, ws_bad, k, fc, fc_exp, rises, exp_ready;
    logic seen32;

    vecs[0] = '{hd_in: 8'd0, fb_in: 8'd7,  exp_rise: 1, exp_period: 2,  exp_frame: 12};
    vecs[1] = '{hd_in: 8'd3, fb_in: 8'd1,  exp_rise: 3, exp_period: 6,  exp_frame: 12};
    vecs[2] = '{hd_in: 8'd2, fb_in: 8'd9,  exp_rise: 2, exp_period: 4,  exp_frame: 32};
    vecs[3] = '{hd_in: 8'd4, fb_in: 8'd3,  exp_rise: 4, exp_period: 8,  exp_frame: 16};
    vecs[4] = '{hd_in: 8'd6, fb_in: 8'd16, exp_rise: 6, exp_period: 12, exp_frame: 192};
    vecs[5] = '{hd_in: 8'd1, fb_in: 8'd2,  exp_rise: 1, exp_period: 2,  exp_frame: 4};

`ifdef MIC_CLKGEN_WARMUP_EN
    exp_ready = 0;
`else
    exp_ready = 1;
`endif

    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    cfg_half_div = '0; cfg_frame_bits = '0;

    // ---- Reset state ----
    step(); step(); step();
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_ready", ready, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_strobes", {sck_rise, sck_fall, frame_start, cfg_ack}, 0);
    rst = 1'b0;
    step();

    // ---- Defaults with en held ----
    en = 1'b1;
    step();
    c0 = cyc;
    chk("def_ready_entry", ready, 0);
    step();
    chk("def_ready_after_entry", ready, exp_ready);
    wait_for(W_RISE, 100, "def_rise1");
    chk("def_first_rise", cyc - c0, 15);
    wait_for(W_FALL, 100, "def_fall1");
    chk("def_first_fall", cyc - c0, 30);
    chk("def_bit_idx_first_fall", bit_idx, 1);
    wait_for(W_RISE, 100, "def_rise2");
    c1 = cyc;
    wait_for(W_RISE, 100, "def_rise3");
    chk("def_period", cyc - c1, 30);
    ws_bad = 0; seen32 = 1'b0; k = 0;
    while (frame_start !== 1'b1 && k < 4000) begin
      step();
      k++;
      if (ws !== (bit_idx >= 8'd32)) ws_bad++;
      if (bit_idx == 8'd32 && ws === 1'b1) seen32 = 1'b1;
    end
    chk("def_frame_seen", frame_start, 1);
    chk("def_frame_len", cyc - c0, 1920);
    chk("def_ws_vs_bit_errs", ws_bad, 0);
    chk("def_ws_high_at_32", seen32, 1);
    chk("def_frame_cnt", frame_cnt, exp_ready);

    // ---- Mid-frame reconfiguration, second load overwrites shadow ----
    f0 = cyc;
    ack0 = ack_cnt;
    repeat (100) step();
    load(8'd7, 8'd8);
    chk("mid_ack_deferred", cfg_ack, 0);
    repeat (50) step();
    load(8'd5, 8'd32);
    wait_for(W_FS, 2500, "mid_fs1");
    f1 = cyc;
    chk("mid_old_frame_len", f1 - f0, 1920);
    chk("mid_ack_at_fs", cfg_ack, 1);
    wait_for(W_RISE, 100, "mid_rise1");
    chk("mid_new_rise", cyc - f1, 5);
    c1 = cyc;
    wait_for(W_RISE, 100, "mid_rise2");
    chk("mid_new_period", cyc - c1, 10);
    wait_for(W_FS, 700, "mid_fs2");
    chk("mid_new_frame_len", cyc - f1, 320);
    step();
    chk("mid_single_ack", ack_cnt - ack0, 1);

    // ---- Drop en at bit_idx 10, drain to IDLE ----
    k = 0;
    while (bit_idx != 8'd10 && k < 400) begin
      step();
      k++;
    end
    chk("drain_reach_bit10", bit_idx, 10);
    c0 = cyc;
    en = 1'b0;
    fc = frame_cnt;
`ifdef MIC_CLKGEN_WARMUP_EN
    fc_exp = fc;
`else
    fc_exp = fc + 1;
`endif
    wait_for(W_FS, 700, "drain_fs");
    chk("drain_fs_time", cyc - c0, 220);
    chk("drain_fs_sck", sck, 0);
    chk("drain_fs_ws", ws, 0);
    chk("drain_fs_ready", ready, 0);
    chk("drain_frame_cnt", frame_cnt, fc_exp);
    rises = 0;
    repeat (60) begin
      step();
      if (sck_rise === 1'b1 || sck === 1'b1) rises++;
    end
    chk("idle_no_sck", rises, 0);
    chk("idle_frame_cnt_held", frame_cnt, fc_exp);
    chk("idle_bit_idx", bit_idx, 0);

    // ---- Table-driven configurations loaded in IDLE ----
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].hd_in, vecs[i].fb_in);
      chk($sformatf("v%0d_ack_idle", i), cfg_ack, 1);
      en = 1'b1;
      step();
      c0 = cyc;
      wait_for(W_RISE, 600, $sformatf("v%0d_rise1", i));
      chk($sformatf("v%0d_first_rise", i), cyc - c0, vecs[i].exp_rise);
      c1 = cyc;
      wait_for(W_RISE, 600, $sformatf("v%0d_rise2", i));
      chk($sformatf("v%0d_period", i), cyc - c1, vecs[i].exp_period);
      wait_for(W_FS, 600, $sformatf("v%0d_fs", i));
      chk($sformatf("v%0d_frame", i), cyc - c0, vecs[i].exp_frame);
      en = 1'b0;
      wait_for(W_FS, 2 * vecs[i].exp_frame + 10, $sformatf("v%0d_drain", i));
      step();
      chk($sformatf("v%0d_idle_sck_ready", i), {sck, ready}, 0);
    end

    // ---- Reset mid-frame with a pending shadow ----
    load(8'd10, 8'd20);
    en = 1'b1;
    step();
    repeat (30) step();
    load(8'd2, 8'd4);
    chk("rstp_ack_pending", cfg_ack, 0);
    step();
    rst = 1'b1;
    step();
    chk("rstp_sck_ws", {sck, ws}, 0);
    chk("rstp_bit_idx", bit_idx, 0);
    chk("rstp_ready", ready, 0);
    chk("rstp_frame_cnt", frame_cnt, 0);
    chk("rstp_strobes", {sck_rise, sck_fall, frame_start, cfg_ack}, 0);
    rst = 1'b0;
    ack0 = ack_cnt;
    step();
    c0 = cyc;
    wait_for(W_RISE, 100, "rstp_rise1");
    chk("rstp_default_rise", cyc - c0, 15);
    c1 = cyc;
    wait_for(W_RISE, 100, "rstp_rise2");
    chk("rstp_default_period", cyc - c1, 30);
    wait_for(W_FS, 2500, "rstp_fs");
    chk("rstp_default_frame", cyc - c0, 1920);
    chk("rstp_no_ack_at_fs", cfg_ack, 0);
    f1 = cyc;
    wait_for(W_RISE, 100, "rstp_rise3");
    chk("rstp_rise_after_fs", cyc - f1, 15);
    chk("rstp_ack_count", ack_cnt - ack0, 0);
    en = 1'b0;
    wait_for(W_FS, 4000, "rstp_drain");

    // ---- ready / warm-up timing ----
    load(8'd1, 8'd2);
    en = 1'b1;
    step();
    chk("rdy_entry", ready, 0);
`ifdef MIC_CLKGEN_WARMUP_EN
    ws_bad = 0;
    for (int f = 0; f < 16; f++) begin
      wait_for(W_FS, 20, "warm_fs");
      if (ready !== 1'b0) ws_bad++;
    end
    chk("warm_ready_low_during", ws_bad, 0);
    step();
    chk("warm_ready_rise", ready, 1);
`else
    step();
    chk("rdy_after_entry", ready, 1);
`endif
    en = 1'b0;
    wait_for(W_FS, 20, "final_drain");
    step();
    chk("final_idle_ready", ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
